// File: rtl/axrm_pkg.sv
// axrm_pkg: shared types, constants and the cell-kind mapping for the
// sequential approximate recursive 8x8 multiplier.
//   state_t     : controller states (IDLE, RUN, DONE)
//   cell_kind_t : which 2x2 cell produces a partial product
//   cell_kind() : maps digit indices (i, j) and approx_en to a cell kind
package axrm_pkg;

  localparam int NPAIR = 4;   // 2-bit digits per 8-bit operand
  localparam int NPP   = 16;  // partial products per operand pair
  localparam int PW    = 16;  // accumulator / result width

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [1:0] {CELL_EXACT, CELL_A, CELL_B} cell_kind_t;

  // Low-order multiplicand digits use the cheapest cell; the high/low corner
  // uses mul2a; the high/high corner carries the most weight and stays exact.
  function automatic cell_kind_t cell_kind(input logic [1:0] i,
                                           input logic [1:0] j,
                                           input logic       approx_en);
    if (!approx_en) return CELL_EXACT;
    if (!i[1])      return CELL_B;
    if (!j[1])      return CELL_A;
    return CELL_EXACT;
  endfunction

endpackage

// File: rtl/axrm_seq_mul_if.sv
// axrm_seq_mul_if: operand and result handshakes of axrm_seq_mul.
//   in_valid/in_ready, in_a, in_b, approx_en : operand channel
//   out_valid/out_ready, out_result, out_approx : result channel
//   master modport: producer/consumer side; slave modport: the multiplier.
interface axrm_seq_mul_if
  import axrm_pkg::*;
;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          approx_en;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_result;
  logic          out_approx;

  modport master (
    output in_valid, in_a, in_b, approx_en, out_ready,
    input  in_ready, out_valid, out_result, out_approx
  );

  modport slave (
    input  in_valid, in_a, in_b, approx_en, out_ready,
    output in_ready, out_valid, out_result, out_approx
  );
endinterface

// File: rtl/axrm_pp_unit.sv
// axrm_pp_unit: the single shared 2x2 partial-product unit.
//   x, y : 2-bit digits;  kind : cell selection;  pp : 4-bit partial product
module axrm_pp_unit
  import axrm_pkg::*;
(
  input  logic [1:0]  x,
  input  logic [1:0]  y,
  input  cell_kind_t  kind,
  output logic [3:0]  pp
);
  logic [3:0] pp_exact;
  logic [3:0] pp_a;
  logic [3:0] pp_b;

  mul2_exact u_exact (.a(x), .b(y), .p(pp_exact));
  mul2a      u_a     (.a(x), .b(y), .p(pp_a));
  mul2b      u_b     (.a(x), .b(y), .p(pp_b));

  always_comb begin
    pp = pp_exact;
    case (kind)
      CELL_A:  pp = pp_a;
      CELL_B:  pp = pp_b;
      default: pp = pp_exact;
    endcase
  end
endmodule

// File: rtl/mul2_exact.sv
// mul2_exact: exact 2x2 unsigned multiplier cell.
//   a, b : 2-bit operands;  p : 4-bit product
module mul2_exact (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  assign p = {2'b00, a} * {2'b00, b};
endmodule

// File: rtl/mul2a.sv
// mul2a: approximate 2x2 cell; exact except 3x3 yields 7 (no carry into bit 3).
//   a, b : 2-bit operands;  p : 4-bit approximate product
module mul2a (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) | (a[0] & b[1]);
  assign p[2] = a[1] & b[1];
  assign p[3] = 1'b0;
endmodule

// File: rtl/mul2b.sv
// mul2b: approximate 2x2 cell; exact product with the LSB dropped
// (1x1 -> 0, 1x3 -> 2, 3x3 -> 8).
//   a, b : 2-bit operands;  p : 4-bit approximate product
module mul2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic all_ones;
  assign all_ones = a[1] & a[0] & b[1] & b[0];
  assign p[3] = all_ones;
  assign p[2] = a[1] & b[1] & ~(a[0] & b[0]);
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[0] = 1'b0;
endmodule

// File: rtl/axrm_seq_mul.sv
// axrm_seq_mul: sequential approximate recursive 8x8 multiplier. Accepts one
// operand pair, walks the 16 digit-pair partial products through one shared
// 2x2 unit (step k: i = k[3:2], j = k[1:0]) and returns the 16-bit sum.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand/result handshakes (axrm_seq_mul_if.slave)
//   busy     : controller is not IDLE
module axrm_seq_mul
  import axrm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  axrm_seq_mul_if.slave  bus,
  output logic           busy
);
  state_t        state_reg, state_next;
  logic [7:0]    a_reg, b_reg;
  logic          approx_reg;
  logic [3:0]    k_reg;
  logic [PW-1:0] acc_reg;

  logic          accept;
  logic [1:0]    idx_i, idx_j;
  logic [1:0]    a_dig [NPAIR];
  logic [1:0]    b_dig [NPAIR];
  cell_kind_t    kind;
  logic [3:0]    pp;
  logic [3:0]    shamt;
  logic [PW-1:0] pp_shift;

  for (genvar gi = 0; gi < NPAIR; gi++) begin : g_dig
    assign a_dig[gi] = a_reg[2*gi +: 2];
    assign b_dig[gi] = b_reg[2*gi +: 2];
  end

  assign idx_i = k_reg[3:2];
  assign idx_j = k_reg[1:0];
  assign kind  = cell_kind(idx_i, idx_j, approx_reg);

  axrm_pp_unit u_pp (
    .x    (a_dig[idx_i]),
    .y    (b_dig[idx_j]),
    .kind (kind),
    .pp   (pp)
  );

  // Weight of digit pair (i, j) is 4^(i+j): shift by 2(i+j), at most 12.
  assign shamt    = {({1'b0, idx_i} + {1'b0, idx_j}), 1'b0};
  assign pp_shift = {{(PW-4){1'b0}}, pp} << shamt;

  // in_ready opens in DONE only when the result is taken on the same edge,
  // so back-to-back transactions lose no cycle and no result is dropped.
  assign bus.in_ready   = (state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready);
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.out_result = acc_reg;
  assign bus.out_approx = approx_reg;
  assign busy           = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (k_reg == 4'(NPP - 1)) state_next = DONE;
      DONE: if (bus.out_ready) state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      approx_reg <= 1'b0;
      k_reg      <= '0;
      acc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg      <= bus.in_a;
        b_reg      <= bus.in_b;
        approx_reg <= bus.approx_en;
        k_reg      <= '0;
        acc_reg    <= '0;
      end else if (state_reg == RUN) begin
        acc_reg <= acc_reg + pp_shift;
        k_reg   <= k_reg + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_axrm_seq_mul.sv
// tb_axrm_seq_mul: directed and random checks of axrm_seq_mul against an
// independent golden model of the approximate recursive product.
module tb_axrm_seq_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   acc_mon = 0;
  int   hs_mon  = 0;

  axrm_seq_mul_if bus ();

  axrm_seq_mul dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)   acc_mon++;
    if (!rst && bus.out_valid && bus.out_ready) hs_mon++;
  end

  // Cell behaviour written from the cell truth tables:
  // mul2b loses the product LSB, mul2a turns 3x3 into 7.
  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                         input logic ap);
    int unsigned sum = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int unsigned x = (a >> (2*i)) & 3;
        int unsigned y = (b >> (2*j)) & 3;
        int unsigned p = x * y;
        if (ap) begin
          if (i < 2)                             p = p - (p % 2);
          else if (j < 2 && x == 3 && y == 3)    p = 7;
        end
        sum += p << (2*(i+j));
      end
    end
    return 16'(sum);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair, wait (bounded) for in_ready, pass the accept edge, then
  // scramble the inputs so a design that re-samples them gets a wrong answer.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ap);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.approx_en = ap;
    #1;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("accept_timeout", 32'(n), 32'd0);
    step();
    bus.in_valid  = 1'b0;
    bus.in_a      = ~a;
    bus.in_b      = ~b;
    bus.approx_en = ~ap;
  endtask

  task automatic wait_out(output int n, input logic rand_ready);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
  endtask

  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ap, input logic [15:0] exp_res);
    int n;
    bus.out_ready = 1'b1;
    send(a, b, ap);
    wait_out(n, 1'b0);
    chk({tag, "_latency"}, 32'(n), 32'd16);
    chk({tag, "_result"},  32'(bus.out_result), 32'(exp_res));
    chk({tag, "_approx"},  32'(bus.out_approx), 32'(ap));
    step();
    chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_idle"},       {31'd0, busy},          32'd0);
    $display("txn %s a=%h b=%h approx=%0d result=%h latency=%0d", tag, a, b, ap, exp_res, n);
  endtask

  initial begin
    int n;
    logic seen;
    logic [15:0] held;
    int acc0, hs0;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.approx_en = 1'b0; bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
    chk("rst_out_result", 32'(bus.out_result),     32'd0);
    chk("rst_out_approx", {31'd0, bus.out_approx}, 32'd0);
    chk("rst_busy",       {31'd0, busy},           32'd0);
    chk("rst_in_ready",   {31'd0, bus.in_ready},   32'd1);

    // Only the exact high/high corner has nonzero digits: 240*240.
    run_one("f0xf0_ap1", 8'hF0, 8'hF0, 1'b1, 16'hE100);
    run_one("ffxff_ap0", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    // 65025 - 425 (mul2b LSB loss) - 800 (mul2a 9->7) = 63800.
    run_one("ffxff_ap1", 8'hFF, 8'hFF, 1'b1, 16'hF938);
    chk("golden_ffxff_ap1", 32'(golden(8'hFF, 8'hFF, 1'b1)), 32'h0000F938);

    // Stall in DONE with a pending pair, then result taken and next accepted together.
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    wait_out(n, 1'b0);
    chk("stall_latency", 32'(n), 32'd16);
    held = bus.out_result;
    chk("stall_result", 32'(held), 32'h000003A8);
    bus.in_valid = 1'b1; bus.in_a = 8'h56; bus.in_b = 8'h78; bus.approx_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_hold_result", 32'(bus.out_result),   32'(held));
      chk("stall_in_ready",    {31'd0, bus.in_ready}, 32'd0);
      chk("stall_valid",       {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
    n = hs_mon;
    step();
    chk("stall_one_handshake", 32'(hs_mon - n), 32'd1);
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.approx_en = 1'b0;
    chk("b2b_valid_low", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_busy",      {31'd0, busy},          32'd1);
    chk("b2b_in_ready",  {31'd0, bus.in_ready},  32'd0);
    wait_out(n, 1'b0);
    chk("b2b_latency", 32'(n), 32'd16);
    chk("b2b_result",  32'(bus.out_result), 32'(golden(8'h56, 8'h78, 1'b1)));
    chk("b2b_approx",  {31'd0, bus.out_approx}, 32'd1);
    $display("txn b2b a=56 b=78 approx=1 result=%h", bus.out_result);
    step();

    // Reset in the middle of RUN at k = 7.
    bus.out_ready = 1'b1;
    send(8'hAB, 8'hCD, 1'b1);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid",  {31'd0, bus.out_valid},  32'd0);
    chk("midrst_out_result", 32'(bus.out_result),     32'd0);
    chk("midrst_out_approx", {31'd0, bus.out_approx}, 32'd0);
    chk("midrst_busy",       {31'd0, busy},           32'd0);
    chk("midrst_in_ready",   {31'd0, bus.in_ready},   32'd1);
    seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {31'd0, seen}, 32'd0);
    run_one("03x05_ap0", 8'h03, 8'h05, 1'b0, 16'h000F);

    // Random pairs with random stalls.
    acc0 = acc_mon;
    hs0  = hs_mon;
    for (int t = 0; t < 1000; t++) begin
      logic [7:0] a, b;
      logic ap;
      int stall;
      a  = 8'($urandom);
      b  = 8'($urandom);
      ap = 1'($urandom_range(0, 1));
      send(a, b, ap);
      wait_out(n, 1'b1);
      if (n != 16) chk("rand_latency", 32'(n), 32'd16);
      held = bus.out_result;
      bus.out_ready = 1'b0;
      stall = $urandom_range(0, 3);
      for (int c = 0; c < stall; c++) step();
      chk("rand_result", 32'(bus.out_result), 32'(golden(a, b, ap)));
      if (bus.out_result !== held) chk("rand_stable", 32'(bus.out_result), 32'(held));
      if (bus.out_approx !== ap)   chk("rand_approx", {31'd0, bus.out_approx}, {31'd0, ap});
      $display("txn rand%0d a=%h b=%h approx=%0d result=%h stall=%0d", t, a, b, ap, bus.out_result, stall);
      bus.out_ready = 1'b1;
      step();
    end
    chk("rand_hs_count", 32'(hs_mon - hs0), 32'(acc_mon - acc0));
    chk("rand_acc_count", 32'(acc_mon - acc0), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
